// File: rtl/bus_cycle_fsm.sv
// bus_cycle_fsm: runs one non-opcode-fetch Z80 bus machine cycle (memory read/write,
// port read/write) on behalf of control_fsm, which supplies the cycle request and
// waits for done.
//
// Ports:
//   clk        system clock, rising edge
//   rst_L      asynchronous active-low reset
//   start      cycle request, sampled only in IDLE
//   cyc_type   0=MR 1=MW 2=PR 3=PW, captured on accepted start
//   addr_in    cycle address, captured on accepted start
//   wdata_in   write data, captured on accepted start
//   busy       state is not IDLE
//   done       one-cycle completion pulse
//   timeout    high with done when the cycle was force-completed
//   rdata_out  read data, valid from done until the next read completes
//   addr_out   external address bus
//   data_out   external write data
//   data_oe    drive enable for data_out
//   data_in    external data bus
//   WAIT_L     external wait request, active-low
//   MREQ_L     memory request, active-low
//   IORQ_L     I/O request, active-low
//   RD_L       read strobe, active-low
//   WR_L       write strobe, active-low
module bus_cycle_fsm #(
  parameter int unsigned IO_WAITS = 1,
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        start,
  input  logic [1:0]  cyc_type,
  input  logic [15:0] addr_in,
  input  logic [7:0]  wdata_in,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  rdata_out,
  output logic [15:0] addr_out,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in,
  input  logic        WAIT_L,
  output logic        MREQ_L,
  output logic        IORQ_L,
  output logic        RD_L,
  output logic        WR_L
);

  localparam logic [1:0] IoWaits = 2'(IO_WAITS);
  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  typedef enum logic [2:0] {StIdle, StT1, StT2, StTa, StTw, StT3} state_e;

  state_e      state_q, state_d;
  logic [1:0]  type_q, type_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [1:0]  auto_q, auto_d;
  logic [7:0]  wait_q, wait_d;
  logic        to_flag_q, to_flag_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;

  // type bit 1 selects I/O, bit 0 selects write
  logic is_io, is_read;
  assign is_io   = type_q[1];
  assign is_read = ~type_q[0];

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    auto_d    = auto_q;
    wait_d    = wait_q;
    to_flag_d = to_flag_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          type_d  = cyc_type;
          addr_d  = addr_in;
          wdata_d = wdata_in;
          state_d = StT1;
        end
      end
      StT1: state_d = StT2;
      StT2: begin
        if (is_io && (IoWaits != 2'd0)) begin
          state_d = StTa;
          auto_d  = 2'd1;
        end else if (!WAIT_L) begin
          // The counter tracks wait states taken, so the first TW counts as 1
          state_d = StTw;
          wait_d  = 8'd1;
        end else begin
          state_d = StT3;
        end
      end
      StTa: begin
        if (auto_q < IoWaits) begin
          auto_d = auto_q + 2'd1;
        end else if (!WAIT_L) begin
          state_d = StTw;
          wait_d  = 8'd1;
        end else begin
          state_d = StT3;
        end
      end
      StTw: begin
        if ((MaxWait != 8'd0) && (wait_q == MaxWait)) begin
          state_d   = StT3;
          to_flag_d = 1'b1;
        end else if (WAIT_L) begin
          state_d = StT3;
        end else if (wait_q != 8'hFF) begin
          wait_d = wait_q + 8'd1;
        end
      end
      StT3: begin
        state_d   = StIdle;
        done_d    = 1'b1;
        timeout_d = to_flag_q;
        to_flag_d = 1'b0;
        wait_d    = 8'd0;
        auto_d    = 2'd0;
        if (is_read) rdata_d = data_in;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q   <= StIdle;
      type_q    <= 2'd0;
      addr_q    <= 16'd0;
      wdata_q   <= 8'd0;
      rdata_q   <= 8'd0;
      auto_q    <= 2'd0;
      wait_q    <= 8'd0;
      to_flag_q <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      auto_q    <= auto_d;
      wait_q    <= wait_d;
      to_flag_q <= to_flag_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  // Moore strobe decode from state and captured type
  logic active;     // T1..T3
  logic late_phase; // T2, TA, TW, T3

  always_comb begin
    active     = (state_q != StIdle);
    late_phase = (state_q == StT2) || (state_q == StTa) || (state_q == StTw) ||
                 (state_q == StT3);
    busy       = active;
    done       = done_q;
    timeout    = timeout_q;
    rdata_out  = rdata_q;
    addr_out   = addr_q;
    data_out   = wdata_q;
    data_oe    = active && !is_read;
    MREQ_L     = !(active && !is_io);
    IORQ_L     = !(late_phase && is_io);
    // Memory reads assert RD_L from T1; I/O reads only from T2
    RD_L       = !(is_read && (is_io ? late_phase : active));
    WR_L       = !(!is_read && late_phase);
  end

endmodule
